// File: rtl/vedic4x4_seq_ctrl.sv
// Sequencing controller for a 4x4 Urdhva Tiryagbhyam multiplier. Partial products are
// summed in two passes through one shared external ripple adder with a settle window.
module vedic4x4_seq_ctrl #(
    parameter int unsigned ADD_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_p,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_cin,
    input  logic [7:0] add_sum,
    input  logic       add_cout,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StAdd1, StAdd2, StDone} state_e;

    localparam logic [3:0] WaitLast = 4'(ADD_WAIT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] q0_q, q1_q, q2_q, q3_q;
    logic [7:0] acc_q, out_p_q;
    logic       err_q;
    logic       accept, cnt_done, capture;

    // 2x2 Vedic block: vertical/crosswise products with a half-adder carry chain.
    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        logic cross_c, top;
        cross_c = (x[1] & y[0]) & (x[0] & y[1]);
        top     = x[1] & y[1];
        return {top & cross_c, top ^ cross_c, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
    endfunction

    assign accept   = in_valid & in_ready;
    assign cnt_done = (cnt_q == WaitLast);
    assign capture  = ((state_q == StAdd1) || (state_q == StAdd2)) && cnt_done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        add_a   = 8'h00;
        add_b   = 8'h00;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StAdd1;
                    cnt_d   = 4'd0;
                end
            end
            StAdd1: begin
                add_a = {q3_q, q0_q};
                add_b = {2'b00, q1_q, 2'b00};
                if (cnt_done) begin
                    cnt_d   = 4'd0;
                    state_d = StAdd2;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StAdd2: begin
                add_a = acc_q;
                add_b = {2'b00, q2_q, 2'b00};
                if (cnt_done) begin
                    cnt_d   = 4'd0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_q    <= 4'd0;
            q1_q    <= 4'd0;
            q2_q    <= 4'd0;
            q3_q    <= 4'd0;
            acc_q   <= 8'd0;
            out_p_q <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                q0_q <= mul2(in_a[1:0], in_b[1:0]);
                q1_q <= mul2(in_a[3:2], in_b[1:0]);
                q2_q <= mul2(in_a[1:0], in_b[3:2]);
                q3_q <= mul2(in_a[3:2], in_b[3:2]);
            end
            if ((state_q == StAdd1) && cnt_done) begin
                acc_q <= add_sum;
            end
            if ((state_q == StAdd2) && cnt_done) begin
                out_p_q <= add_sum;
            end
            // A carry-out can never occur for a valid product, so it marks an adder fault.
            if (capture && add_cout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_p     = out_p_q;
    assign add_cin   = 1'b0;
    assign err       = err_q;

endmodule

// File: tb/tb_vedic4x4_seq_ctrl.sv
// Self-checking bench for vedic4x4_seq_ctrl: one instance with ADD_WAIT=0 and one with
// ADD_WAIT=3, each driving a behavioural 8-bit adder model.
module tb_vedic4x4_seq_ctrl;

    logic clk;
    logic rst_n;

    logic       in_valid0, in_ready0, out_valid0, out_ready0, add_cin0, add_cout0, err0;
    logic [3:0] in_a0, in_b0;
    logic [7:0] out_p0, add_a0, add_b0, add_sum0;
    logic [8:0] sum0;
    logic       force_cout0;

    logic       in_valid3, in_ready3, out_valid3, out_ready3, add_cin3, add_cout3, err3;
    logic [3:0] in_a3, in_b3;
    logic [7:0] out_p3, add_a3, add_b3, add_sum3;
    logic [8:0] sum3;

    int n_cmp;
    int n_err;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;
    vec_t vecs[6];

    assign sum0      = {1'b0, add_a0} + {1'b0, add_b0} + {8'd0, add_cin0};
    assign add_sum0  = sum0[7:0];
    assign add_cout0 = sum0[8] | force_cout0;
    assign sum3      = {1'b0, add_a3} + {1'b0, add_b3} + {8'd0, add_cin3};
    assign add_sum3  = sum3[7:0];
    assign add_cout3 = sum3[8];

    vedic4x4_seq_ctrl #(.ADD_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_p(out_p0),
        .add_a(add_a0), .add_b(add_b0), .add_cin(add_cin0),
        .add_sum(add_sum0), .add_cout(add_cout0), .err(err0)
    );

    vedic4x4_seq_ctrl #(.ADD_WAIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_a(in_a3), .in_b(in_b3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_p(out_p3),
        .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3),
        .add_sum(add_sum3), .add_cout(add_cout3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction on the ADD_WAIT=0 instance; expected product comes from the caller.
    task automatic run_op0(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p,
                           output int lat);
        int n;
        n = 0;
        while (!in_ready0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_a0      = a;
        in_b0      = b;
        in_valid0  = 1'b1;
        out_ready0 = 1'b1;
        exp_q.push_back(p);
        @(negedge clk);
        in_valid0 = 1'b0;
        lat = 1;
        while (!out_valid0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: no out_valid for %0d*%0d", a, b);
            void'(exp_q.pop_front());
        end else begin
            check($sformatf("prod %0d*%0d", a, b), {24'd0, out_p0}, {24'd0, exp_q.pop_front()});
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{a: 4'd13, b: 4'd11, p: 8'h8F};
        vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
        vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'h00};
        vecs[3] = '{a: 4'd1,  b: 4'd15, p: 8'h0F};
        vecs[4] = '{a: 4'd7,  b: 4'd6,  p: 8'h2A};
        vecs[5] = '{a: 4'd10, b: 4'd12, p: 8'h78};

        rst_n = 1'b0;
        in_valid0 = 1'b0; in_a0 = 4'd0; in_b0 = 4'd0; out_ready0 = 1'b1; force_cout0 = 1'b0;
        in_valid3 = 1'b0; in_a3 = 4'd0; in_b3 = 4'd0; out_ready3 = 1'b1;

        // Reset state
        #12;
        check("rst in_ready", {31'd0, in_ready0}, 32'd0);
        check("rst in_ready3", {31'd0, in_ready3}, 32'd0);
        check("rst out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst out_p", {24'd0, out_p0}, 32'd0);
        check("rst err", {31'd0, err0}, 32'd0);
        check("rst add_a", {24'd0, add_a0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready", {31'd0, in_ready0}, 32'd1);

        // 13*11 step by step
        @(negedge clk);
        in_a0 = 4'd13; in_b0 = 4'd11; in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        check("13x11 add1 a", {24'd0, add_a0}, 32'h63);
        check("13x11 add1 b", {24'd0, add_b0}, 32'h24);
        check("13x11 cin", {31'd0, add_cin0}, 32'd0);
        check("13x11 in_ready busy", {31'd0, in_ready0}, 32'd0);
        @(negedge clk);
        check("13x11 add2 a", {24'd0, add_a0}, 32'h87);
        check("13x11 add2 b", {24'd0, add_b0}, 32'h08);
        check("13x11 no early valid", {31'd0, out_valid0}, 32'd0);
        @(negedge clk);
        check("13x11 out_valid", {31'd0, out_valid0}, 32'd1);
        check("13x11 out_p", {24'd0, out_p0}, 32'h8F);
        check("13x11 done add_a", {24'd0, add_a0}, 32'd0);
        check("13x11 err", {31'd0, err0}, 32'd0);
        @(negedge clk);

        // Table vectors with latency check (3 sampling points = valid after 2 edges)
        for (int i = 0; i < 6; i++) begin
            run_op0(vecs[i].a, vecs[i].b, vecs[i].p, lat);
            check($sformatf("latency vec%0d", i), lat, 32'd3);
        end

        // Exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op0(4'(a), 4'(b), 8'(a * b), lat);
            end
        end
        check("sweep err", {31'd0, err0}, 32'd0);

        // Back-pressure
        out_ready0 = 1'b0;
        in_a0 = 4'd9; in_b0 = 4'd9; in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid0 = i[0];
            in_a0 = 4'(i);
            @(negedge clk);
            check("bp out_p", {24'd0, out_p0}, 32'd81);
            check("bp in_ready", {31'd0, in_ready0}, 32'd0);
            check("bp out_valid", {31'd0, out_valid0}, 32'd1);
        end
        in_valid0 = 1'b1; in_a0 = 4'd2; in_b0 = 4'd3; out_ready0 = 1'b1;
        @(negedge clk);
        check("bp idle in_ready", {31'd0, in_ready0}, 32'd1);
        check("bp idle out_valid", {31'd0, out_valid0}, 32'd0);
        check("bp idle out_p held", {24'd0, out_p0}, 32'd81);
        @(negedge clk);
        in_valid0 = 1'b0;
        check("bp next accepted", {31'd0, in_ready0}, 32'd0);
        check("bp next add_a", {24'd0, add_a0}, 32'h06);
        @(negedge clk);
        @(negedge clk);
        check("bp next out_valid", {31'd0, out_valid0}, 32'd1);
        check("bp next out_p", {24'd0, out_p0}, 32'd6);
        @(negedge clk);

        // ADD_WAIT=3, 7*6 on the second instance
        in_a3 = 4'd7; in_b3 = 4'd6; in_valid3 = 1'b1;
        exp_q.push_back(8'h2A);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            in_valid3 = 1'b0;
            check($sformatf("w3 add_a c%0d", k), {24'd0, add_a3}, (k <= 4) ? 32'h16 : 32'h1E);
            check($sformatf("w3 add_b c%0d", k), {24'd0, add_b3}, (k <= 4) ? 32'h08 : 32'h0C);
            check($sformatf("w3 no valid c%0d", k), {31'd0, out_valid3}, 32'd0);
        end
        @(negedge clk);
        check("w3 out_valid", {31'd0, out_valid3}, 32'd1);
        check("w3 out_p", {24'd0, out_p3}, {24'd0, exp_q.pop_front()});
        @(negedge clk);

        // Fault injection on ADD1 capture of 3*3
        in_a0 = 4'd3; in_b0 = 4'd3; in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        check("fault pre err", {31'd0, err0}, 32'd0);
        force_cout0 = 1'b1;
        @(negedge clk);
        force_cout0 = 1'b0;
        check("fault err set", {31'd0, err0}, 32'd1);
        @(negedge clk);
        check("fault out_p", {24'd0, out_p0}, 32'd9);
        @(negedge clk);
        run_op0(4'd4, 4'd5, 8'd20, lat);
        check("fault err sticky 1", {31'd0, err0}, 32'd1);
        run_op0(4'd6, 4'd6, 8'd36, lat);
        check("fault err sticky 2", {31'd0, err0}, 32'd1);

        // Reset mid-ADD2
        in_a0 = 4'd14; in_b0 = 4'd13; in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst out_valid", {31'd0, out_valid0}, 32'd0);
        check("midrst in_ready", {31'd0, in_ready0}, 32'd0);
        check("midrst out_p", {24'd0, out_p0}, 32'd0);
        check("midrst add_a", {24'd0, add_a0}, 32'd0);
        check("midrst err", {31'd0, err0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst release in_ready", {31'd0, in_ready0}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst no product", {31'd0, out_valid0}, 32'd0);
        end
        run_op0(4'd5, 4'd5, 8'h19, lat);
        check("midrst next err", {31'd0, err0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
